// File: rtl/button_wb_controller_if.sv
// Wishbone pipelined bus between the button controller and the LED output device.
// Signal suffixes are from the controller's point of view.
interface wishbone #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) ();
  logic                   cyc_o;
  logic                   stb_o;
  logic                   we_o;
  logic [AddrWidth-1:0]   adr_o;
  logic [DataWidth-1:0]   dat_o;
  logic [DataWidth/8-1:0] sel_o;
  logic                   ack_i;
  logic                   err_i;
  logic                   rty_i;
  logic                   stall_i;

  modport controller (
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    input  ack_i, err_i, rty_i, stall_i
  );

  modport device (
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    output ack_i, err_i, rty_i, stall_i
  );
endinterface

// File: rtl/button_wb_controller.sv
// Debounces push buttons into an 8-bit LED pattern and mirrors every pattern change to the
// LED device with single-beat Wishbone pipelined writes, retrying on err/rty/timeout.
module button_wb_controller #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter logic [31:0] LED_ADDR        = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_BUTTONS-1:0] buttons_i,
  wishbone.controller            wb,
  output logic [7:0]             pattern_o,
  output logic                   busy_o,
  output logic                   bus_error_o
);

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RetW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StBackoff} state_e;

  state_e                 state_q, state_d;
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q, stable_q, stable_d, press_q, press_d;
  logic [DbW-1:0]         db_cnt_q [NUM_BUTTONS];
  logic [DbW-1:0]         db_cnt_d [NUM_BUTTONS];
  logic [7:0]             pattern_q, pattern_d, latch_q;
  logic                   pending_q, pending_d, take;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [RetW-1:0]        retry_q, retry_d;
  logic                   ack_q, err_q, rty_q;
  logic                   bus_error_q, err_set;
  logic [3:0]             press_ext, press_cnt;

  // Per-button debounce: a level change is accepted after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    stable_d = stable_q;
    press_d  = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press_ext                  = '0;
    press_ext[NUM_BUTTONS-1:0] = press_q;
    press_cnt                  = '0;
    for (int i = 0; i < 4; i++) begin
      press_cnt = press_cnt + 4'(press_ext[i]);
    end
    pattern_d = {pattern_q[7:4] + press_cnt, pattern_q[3:0] ^ press_ext};
    // A press landing in the same cycle as the IDLE hand-off keeps pending set.
    pending_d = (pending_q & ~take) | (|press_q);
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    tmo_d   = '0;
    take    = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          take    = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StBackoff;
        end else if (!wb.stall_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        if (err_q || rty_q) begin
          state_d = StBackoff;
        end else if (ack_q) begin
          state_d = StIdle;
          retry_d = '0;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StBackoff;
        end
      end
      StBackoff: begin
        if (retry_q < RetW'(MAX_RETRIES)) begin
          retry_d = retry_q + 1'b1;
          state_d = StReq;
        end else begin
          retry_d = '0;
          err_set = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    wb.cyc_o = 1'b0;
    wb.stb_o = 1'b0;
    unique case (state_q)
      StReq: begin
        wb.cyc_o = 1'b1;
        wb.stb_o = 1'b1;
      end
      StWait:  wb.cyc_o = 1'b1;
      default: ;
    endcase
  end

  assign wb.we_o      = wb.cyc_o;
  assign wb.adr_o     = LED_ADDR;
  assign wb.sel_o     = '1;
  assign wb.dat_o     = {24'h0, latch_q};
  assign pattern_o    = pattern_q;
  assign busy_o       = (state_q != StIdle);
  assign bus_error_o  = bus_error_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      press_q     <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt_q[i] <= '0;
      pattern_q   <= '0;
      latch_q     <= '0;
      pending_q   <= 1'b1;
      tmo_q       <= '0;
      retry_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rty_q       <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= buttons_i;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      press_q     <= press_d;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt_q[i] <= db_cnt_d[i];
      pattern_q   <= pattern_d;
      pending_q   <= pending_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      // Responses are registered; only those seen while waiting count.
      ack_q       <= (state_q == StWait) & wb.ack_i;
      err_q       <= (state_q == StWait) & wb.err_i;
      rty_q       <= (state_q == StWait) & wb.rty_i;
      if (take)    latch_q     <= pattern_q;
      if (err_set) bus_error_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_button_wb_controller.sv
// Scoreboard bench: each expected write attempt is queued by the stimulus and checked by a
// monitor when the corresponding cyc_o window closes.
module tb_button_wb_controller;
  localparam int unsigned NB = 4;
  localparam int RspAck  = 0;
  localparam int RspErr  = 1;
  localparam int RspRty  = 2;
  localparam int RspNone = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NB-1:0] buttons = '0;
  logic [7:0]    pattern;
  logic          busy, bus_error;

  wishbone wb_bus ();

  button_wb_controller #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(4),
    .LED_ADDR       (32'h0),
    .TIMEOUT_CYCLES (16),
    .MAX_RETRIES    (3)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .buttons_i  (buttons),
    .wb         (wb_bus),
    .pattern_o  (pattern),
    .busy_o     (busy),
    .bus_error_o(bus_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Device model: response per accepted attempt is taken from rsp_code[accept_cnt].
  int rsp_code [0:63];
  int accept_cnt = 0;
  int stall_load = 0;
  int stall_seen = 0;

  assign wb_bus.stall_i = wb_bus.cyc_o && wb_bus.stb_o && (stall_seen < stall_load);

  initial begin
    wb_bus.ack_i = 1'b0;
    wb_bus.err_i = 1'b0;
    wb_bus.rty_i = 1'b0;
    forever begin
      @(posedge clk);
      wb_bus.ack_i <= 1'b0;
      wb_bus.err_i <= 1'b0;
      wb_bus.rty_i <= 1'b0;
      if (wb_bus.cyc_o === 1'b1 && wb_bus.stb_o === 1'b1) begin
        if (wb_bus.stall_i) begin
          stall_seen <= stall_seen + 1;
        end else begin
          stall_seen <= 0;
          case (rsp_code[accept_cnt % 64])
            RspAck:  wb_bus.ack_i <= 1'b1;
            RspErr:  wb_bus.err_i <= 1'b1;
            RspRty:  wb_bus.rty_i <= 1'b1;
            default: ;
          endcase
          accept_cnt++;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] dat;
    int         cyc_len;
    int         stb_len;
  } wr_t;

  wr_t exp_q[$];

  // Monitor: measure each cyc_o window and compare against the oldest expected attempt.
  initial begin
    int          run_cyc;
    int          run_stb;
    logic [31:0] run_dat;
    logic        run_ok;
    wr_t         e;
    run_cyc = 0;
    run_stb = 0;
    run_dat = '0;
    run_ok  = 1'b1;
    forever begin
      @(negedge clk);
      if (wb_bus.cyc_o === 1'b1) begin
        run_cyc++;
        if (wb_bus.stb_o === 1'b1) begin
          run_stb++;
          run_dat = wb_bus.dat_o;
        end
        if (!(wb_bus.we_o === 1'b1 && wb_bus.adr_o === 32'h0 && wb_bus.sel_o === 4'hf))
          run_ok = 1'b0;
      end else if (run_cyc != 0) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_data", run_dat, {24'h0, e.dat});
          check("write_cyc_len", 32'(run_cyc), 32'(e.cyc_len));
          check("write_stb_len", 32'(run_stb), 32'(e.stb_len));
          check("write_bus_attrs", 32'(run_ok), 32'd1);
        end
        run_cyc = 0;
        run_stb = 0;
        run_ok  = 1'b1;
      end
    end
  end

  task automatic push_wr(input logic [7:0] dat, input int cyc_len, input int stb_len,
                         input int times);
    wr_t e;
    e.dat     = dat;
    e.cyc_len = cyc_len;
    e.stb_len = stb_len;
    for (int k = 0; k < times; k++) exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int settle, input int limit);
    int n;
    n = 0;
    repeat (settle) @(posedge clk);
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic press(input logic [NB-1:0] mask, input int hold);
    @(posedge clk);
    #1 buttons = mask;
    repeat (hold) @(posedge clk);
    #1 buttons = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pattern", 32'(pattern), 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bus_error", 32'(bus_error), 32'd0);
    check("reset_cyc_stb", {30'h0, wb_bus.cyc_o, wb_bus.stb_o}, 32'h0);
    check("reset_dat", wb_bus.dat_o, 32'h0);
    push_wr(8'h00, 3, 1, 1);
    rst_n = 1'b1;
    wait_idle("init_write_idle", 2, 30);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rsp_code[i] = RspAck;
    #1 rst_n = 1'b0;
    do_reset();

    // Debounced press of button 1, then a 3-cycle glitch on button 0 that must be ignored.
    push_wr(8'h12, 3, 1, 1);
    press(4'b0010, 10);
    wait_idle("press1_idle", 12, 40);
    check("press1_pattern", 32'(pattern), 32'h12);
    press(4'b0001, 3);
    repeat (20) @(posedge clk);
    #1;
    check("glitch_pattern", 32'(pattern), 32'h12);
    check("glitch_busy", 32'(busy), 32'd0);

    // Simultaneous presses from a fresh pattern.
    do_reset();
    push_wr(8'h25, 3, 1, 1);
    press(4'b0101, 10);
    wait_idle("dual_idle", 12, 40);
    check("dual_pattern", 32'(pattern), 32'h25);

    // Three stalled request cycles.
    stall_load = 3;
    push_wr(8'h3d, 6, 4, 1);
    press(4'b1000, 10);
    wait_idle("stall_idle", 12, 40);
    stall_load = 0;
    check("stall_pattern", 32'(pattern), 32'h3d);

    // err on attempt 1, rty on attempt 2, ack on attempt 3.
    rsp_code[accept_cnt % 64]       = RspErr;
    rsp_code[(accept_cnt + 1) % 64] = RspRty;
    push_wr(8'h4c, 3, 1, 3);
    press(4'b0001, 10);
    wait_idle("retry_idle", 12, 60);
    check("retry_pattern", 32'(pattern), 32'h4c);
    check("retry_bus_error", 32'(bus_error), 32'd0);

    // Device never answers: four 16-cycle attempts then the write is dropped.
    for (int k = 0; k < 4; k++) rsp_code[(accept_cnt + k) % 64] = RspNone;
    push_wr(8'h5e, 16, 1, 4);
    press(4'b0010, 10);
    wait_idle("timeout_idle", 12, 200);
    check("timeout_pattern", 32'(pattern), 32'h5e);
    check("timeout_bus_error", 32'(bus_error), 32'd1);

    // Later press still writes; error flag stays sticky.
    push_wr(8'h6a, 3, 1, 1);
    press(4'b0100, 10);
    wait_idle("after_error_idle", 12, 40);
    check("after_error_pattern", 32'(pattern), 32'h6a);
    check("after_error_bus_error", 32'(bus_error), 32'd1);

    repeat (5) @(posedge clk);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_wb_controller.md
Name: button_wb_controller

Overview:
- Wishbone pipelined initiator that turns debounced push-button presses into single-beat write cycles to the LED output device.
- Keeps an 8-bit LED pattern:
  - bits [3:0] toggle per button.
  - bits [7:4] count total presses, mod 16.
- On every pattern change it writes the pattern to LED_ADDR, retrying on error, retry-response or timeout.
- Also performs one initial write of 0 after reset so the device and the pattern agree.

Parameters:
- NUM_BUTTONS, 4, number of button inputs. Legal range 1..4.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a level change.
- LED_ADDR, 0, Wishbone address driven on adr_o.
- TIMEOUT_CYCLES, 16, maximum cycles with cyc_o high before the attempt is abandoned.
- MAX_RETRIES, 3, retries after the first failed attempt before the write is dropped.

Ports:
- clk_i  input  1  system clock; also the Wishbone clock.
- rst_ni  input  1  asynchronous active-low reset.
- buttons_i  input  NUM_BUTTONS  raw asynchronous button levels; 1 = pressed.
- wb  interface  wishbone.controller  drives cyc_o, stb_o, we_o, adr_o, dat_o, sel_o; samples ack_i, err_i, rty_i, stall_i.
- pattern_o  output  8  current pattern.
- busy_o  output  1  high whenever the FSM is not in IDLE.
- bus_error_o  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (rst_ni low, asynchronous) sets all of the following to 0:
  - pattern_o, busy_o, bus_error_o, cyc_o, stb_o, we_o, dat_o.
  - Debounce state and counters; synchronizer flops.
  - The pending flag is set to 1 so the INIT write occurs.
- Constant outputs: adr_o = LED_ADDR; sel_o all ones; we_o = cyc_o.
- Reset asserted mid-cycle drops cyc_o and stb_o immediately. No completion is owed.
- Synchronizer: 2 flops per button.
- Debounce, per button:
  - A counter increments while the synced level differs from the stable level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
  - A 0->1 flip of the stable level produces a one-cycle press pulse.
  - A glitch shorter than DEBOUNCE_CYCLES never flips the stable level.
- Pattern update, registered one cycle after the pulses:
  - Bit i toggles for every pressing button i.
  - Bits [7:4] add the popcount of the simultaneous pulses, wrapping mod 16.
  - The pending flag is set.
- dat_o is zero-extended from an 8-bit latched value.
- FSM states and transitions:
  - IDLE: if pending, then latch = pattern, clear pending, go to REQ. A press in that same cycle re-sets pending; set wins over clear.
  - REQ: cyc=stb=1. If stall_i=0, go to WAIT; otherwise hold.
  - WAIT: cyc=1, stb=0. Response is sampled from the cycle after acceptance:
    - ack_i → IDLE, retry count cleared.
    - err_i or rty_i → BACKOFF. err_i takes priority over ack_i if both are high.
  - Timeout counter: counts every cycle in REQ and WAIT and clears on entry to REQ. Reaching TIMEOUT_CYCLES → BACKOFF.
  - BACKOFF: cyc=0 for exactly 1 cycle.
    - If retries < MAX_RETRIES: increment retries, go to REQ with the same latched data.
    - Otherwise: set bus_error_o, clear retries, go to IDLE.
- Presses during a transaction coalesce into one follow-up write carrying the newest pattern.
- Latency: press pulse → pattern_o updates 1 cycle later → IDLE→REQ 1 cycle later. With stall_i=0 and a registered ack, cyc_o is high for 3 cycles.

Test Plan:
- Reset release, no stall, device acks 1 cycle after acceptance → one write of dat=0x00. cyc_o high 3 cycles, then busy_o=0.
- DEBOUNCE_CYCLES=4; hold button 1 high for 10 cycles → pattern 0x12 and one write of 0x12. A 3-cycle glitch on button 0 → no change, no write.
- Presses on buttons 0 and 2 in the same cycle from pattern 0x00 → pattern 0x25 and a single write of 0x25.
- stall_i held high for 3 cycles → stb_o stays high for those cycles. Write completes; no timeout with TIMEOUT_CYCLES=16.
- err_i on attempt 1 and rty_i on attempt 2, then ack → 3 writes of identical data, each separated by 1 cycle of cyc_o low. bus_error_o stays 0.
- Device never acks, MAX_RETRIES=3, TIMEOUT_CYCLES=16 → 4 attempts of 16 cycles each, then bus_error_o=1 and the FSM is in IDLE. A later press still issues a write.
